// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the four-way memory arbiter.
// The arbiter connects through the master modport; requesters and the memory unit use slave.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

interface mem_arbiter_if;
  // Requester side, four packed slices
  logic [3:0]                        req_execute;
  logic [4*`MEMORY_ADDR_WIDTH-1:0]   req_address1;
  logic [4*`MEMORY_ADDR_WIDTH-1:0]   req_address2;
  logic [7:0]                        req_func;
  logic [4*`MEMORY_DATA_WIDTH-1:0]   req_write_data;
  logic [3:0]                        req_ready;
  logic [`MEMORY_DATA_WIDTH-1:0]     req_read_data1;
  logic [`MEMORY_DATA_WIDTH-1:0]     req_read_data2;

  // Memory-unit side
  logic                              mem_execute;
  logic [`MEMORY_ADDR_WIDTH-1:0]     address1;
  logic [`MEMORY_ADDR_WIDTH-1:0]     address2;
  logic [1:0]                        mem_func;
  logic [`MEMORY_DATA_WIDTH-1:0]     write_data;
  logic                              mem_ready;
  logic [`MEMORY_DATA_WIDTH-1:0]     read_data1;
  logic [`MEMORY_DATA_WIDTH-1:0]     read_data2;

  modport master (
    input  req_execute, req_address1, req_address2, req_func, req_write_data,
    output req_ready, req_read_data1, req_read_data2,
    output mem_execute, address1, address2, mem_func, write_data,
    input  mem_ready, read_data1, read_data2
  );

  modport slave (
    output req_execute, req_address1, req_address2, req_func, req_write_data,
    input  req_ready, req_read_data1, req_read_data2,
    input  mem_execute, address1, address2, mem_func, write_data,
    output mem_ready, read_data1, read_data2
  );
endinterface

// File: rtl/mem_arbiter.sv
// Four-requester round-robin arbiter in front of a single memory unit:
// captures requests, issues one transaction at a time, aborts on timeout.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          arb_busy,
  output logic [1:0]    arb_grant,
  output logic [1:0]    arb_error
);
  localparam int AW = `MEMORY_ADDR_WIDTH;
  localparam int DW = `MEMORY_DATA_WIDTH;
  localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state_q, state_d;
  logic [3:0] pending_q;
  logic [9:0] timer_q;

  logic [AW-1:0] cap_addr1 [4];
  logic [AW-1:0] cap_addr2 [4];
  logic [1:0]    cap_func  [4];
  logic [DW-1:0] cap_wdata [4];

  logic       issue, complete, abort;
  logic       sel_valid;
  logic [1:0] sel, scan_idx;
  logic [3:0] clear_vec, capture_vec, dup_vec;

  // Round-robin pick: first pending index starting just after the last grant.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    scan_idx  = '0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = arb_grant + 2'(k + 1);
      if (pending_q[scan_idx]) begin
        sel       = scan_idx;
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A slot being retired this edge may take a fresh request in the same edge.
  always_comb begin
    clear_vec = '0;
    if (complete || abort) clear_vec[arb_grant] = 1'b1;
    capture_vec = bus.req_execute & (~pending_q | clear_vec);
    dup_vec     = bus.req_execute & pending_q & ~clear_vec;
  end

  // NOTE: capture slots carry no reset; a slot is only read after a capture has loaded it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (capture_vec[i]) begin
        cap_addr1[i] <= bus.req_address1[i*AW +: AW];
        cap_addr2[i] <= bus.req_address2[i*AW +: AW];
        cap_func[i]  <= bus.req_func[i*2 +: 2];
        cap_wdata[i] <= bus.req_write_data[i*DW +: DW];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= IDLE;
      pending_q          <= '0;
      timer_q            <= '0;
      arb_grant          <= '0;
      arb_error          <= '0;
      bus.mem_execute    <= 1'b0;
      bus.address1       <= '0;
      bus.address2       <= '0;
      bus.mem_func       <= '0;
      bus.write_data     <= '0;
      bus.req_ready      <= '0;
      bus.req_read_data1 <= '0;
      bus.req_read_data2 <= '0;
    end else begin
      state_q         <= state_d;
      pending_q       <= (pending_q & ~clear_vec) | capture_vec;
      bus.mem_execute <= 1'b0;
      bus.req_ready   <= '0;

      if (|dup_vec) arb_error[0] <= 1'b1;

      if (issue) begin
        arb_grant       <= sel;
        bus.address1    <= cap_addr1[sel];
        bus.address2    <= cap_addr2[sel];
        bus.mem_func    <= cap_func[sel];
        bus.write_data  <= cap_wdata[sel];
        bus.mem_execute <= 1'b1;
        timer_q         <= '0;
      end

      if (state_q == WAIT && !complete && !abort) timer_q <= timer_q + 10'd1;

      if (complete) begin
        bus.req_read_data1 <= bus.read_data1;
        bus.req_read_data2 <= bus.read_data2;
        bus.req_ready      <= 4'b0001 << arb_grant;
      end

      if (abort) arb_error[1] <= 1'b1;
    end
  end

  assign arb_busy = (state_q == WAIT);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, meaning max WAIT cycles before abort (10-bit counter).
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req_execute  input  4  per-requester issue strobe, index 0..3.
REQ-006 req_address1  input  4*`memory_addr_width  packed per-requester address1; requester i at slice i.
REQ-007 req_address2  input  4*`memory_addr_width  packed per-requester address2.
REQ-008 req_func  input  8  packed per-requester 2-bit mem_func.
REQ-009 req_write_data  input  4*`memory_data_width  packed per-requester write data.
REQ-010 req_ready  output  4  one-hot one-cycle completion pulse to requester.
REQ-011 req_read_data1, req_read_data2  output  `memory_data_width each  registered read data, shared by all requesters.
REQ-012 mem_execute  output  1  issue strobe to memory unit.
REQ-013 address1, address2  output  `memory_addr_width each  to memory unit.
REQ-014 mem_func  output  2  to memory unit.
REQ-015 write_data  output  `memory_data_width  to memory unit.
REQ-016 mem_ready, read_data1, read_data2  input  1 / `memory_data_width / `memory_data_width  from memory unit.
REQ-017 arb_busy  output  1  high while in WAIT.
REQ-018 arb_grant  output  2  index of current/last granted requester.
REQ-019 arb_error  output  2  sticky: bit0 duplicate request, bit1 timeout.

Function
REQ-020 Capture: req_execute[i] high at an edge with pending[i]=0 -> pending[i]<=1 and address1/address2/func/write_data of slice i latched; later changes on slice i ignored.
REQ-021 req_execute[i] high while pending[i]=1 and not being cleared that edge -> request dropped, arb_error[0]<=1.
REQ-022 Same-edge clear and new req_execute[i] -> new request captured (set wins), no error.
REQ-023 States: IDLE, WAIT.
REQ-024 IDLE with any pending bit set -> select first pending index scanning from (arb_grant+1) mod 4 upward with wrap; arb_grant<=sel, drive captured fields onto memory outputs, mem_execute<=1, timeout counter<=0, state<=WAIT.
REQ-025 IDLE evaluates registered pending only: minimum two edges from req_execute sample to mem_execute high.
REQ-026 WAIT: mem_execute high exactly one cycle, then 0; address/func/write_data held stable throughout WAIT.
REQ-027 WAIT and mem_ready high -> req_read_data1/2<=read_data1/2, req_ready[arb_grant]<=1 for one cycle, pending[arb_grant]<=0, state<=IDLE.
REQ-028 Back-to-back: next grant may issue on the edge after return to IDLE; requesters may issue while another is served.
REQ-029 WAIT counter reaching TIMEOUT_CYCLES without mem_ready -> arb_error[1]<=1, pending[arb_grant]<=0, no req_ready pulse, state<=IDLE.
REQ-030 mem_ready high in IDLE -> ignored.
REQ-031 req_ready is zero in all cycles except REQ-027 completion pulse.

Reset
REQ-032 rst low -> state IDLE, pending 0, all outputs 0 (mem_execute, address1/2, mem_func, write_data, req_ready, req_read_data1/2, arb_busy, arb_grant, arb_error), counter 0.
REQ-033 Reset mid-WAIT aborts transaction; no req_ready pulse after reset release.

Verification
V-1 Single: req_execute[1] one cycle, address1=0x10, func=GET_CONTENTS; mem_ready 3 cycles after mem_execute with read_data1=0xABC -> mem_execute 2 edges after request, address1=0x10, req_ready=4'b0010 one cycle, req_read_data1=0xABC.
V-2 Contention: req_execute=4'b1111 same cycle, arb_grant=3 after reset-and-prior-use -> grant order 0,1,2,3, each with own address, one ready pulse each.
V-3 Capture hold: requester 2 issues with func=SET_CONTENTS then drops func to 0 next cycle (incr-style) -> mem_func=SET_CONTENTS throughout WAIT.
V-4 Duplicate: req_execute[0] twice while pending[0] -> arb_error=2'b01, one memory transaction only.
V-5 Timeout: TIMEOUT_CYCLES=8, mem_ready never -> arb_error[1]=1 after 8 WAIT cycles, return to IDLE, next pending request served.
V-6 Reset mid-WAIT: rst low during WAIT -> all outputs 0, no req_ready after release.
